// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the registered MIPS write-back stage.
//   SZ_*        load-size encodings carried on in_c_size
//   wb_state_t  write-back sequencer states
//   wb_ld_ctrl_t control bits captured with a load while its data is pending
package wb_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_LOAD = 2'b01,
        HALTED    = 2'b10
    } wb_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       sign;
        logic       halt;
        logic [1:0] size;
    } wb_ld_ctrl_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational sub-word load alignment and extension.
// Ports:
//   rdata   [DATA_W-1:0]  raw data returned by the data memory
//   addr_lo [AW-1:0]      byte offset of the access within the data word
//   size    [1:0]         SZ_BYTE / SZ_HALF / SZ_WORD / SZ_DWORD
//   sign                  1: sign-extend, 0: zero-extend
//   ext     [DATA_W-1:0]  aligned, extended load value
module wb_load_align
    import wb_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned AW     = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [AW-1:0]     addr_lo,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [DATA_W-1:0] ext
);

    logic [AW-1:0]     off;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] word_ext;

    // Offset forced to the natural alignment of the access size.
    // Dword never shifts; on a 32-bit datapath a word offset is always 0 too.
    always_comb begin
        off = '0;
        case (size)
            SZ_BYTE: off = addr_lo;
            SZ_HALF: off = addr_lo & ~AW'(1);
            SZ_WORD: off = addr_lo & ~AW'(3);
            default: off = '0;
        endcase
    end

    assign sh = rdata >> {off, 3'b000};

    assign word_ext = sign ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0]);

    // Extension from the access width; dword on a 32-bit datapath acts as word.
    always_comb begin
        ext = '0;
        case (size)
            SZ_BYTE: ext = sign ? DATA_W'($signed(sh[7:0]))  : DATA_W'(sh[7:0]);
            SZ_HALF: ext = sign ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]);
            SZ_WORD: ext = word_ext;
            default: ext = (DATA_W == 64) ? sh : word_ext;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered MIPS write-back stage with valid/ready intake,
// variable-latency load wait, sub-word load alignment and sticky halt.
// Optional feature macro: WB_RETIRE_CNT_EN (saturating retire counter;
// when undefined retire_count is tied to 0).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   MEM-stage handshake (in_ready only in IDLE)
//   in_alu_out          ALU result
//   in_pc_plus4         link value, zero-extended
//   in_addr_lo          load byte offset
//   in_reg_to_write     destination register index
//   in_c_*              control bits (data_source=1 is a load, jump!=0 links)
//   mem_rvalid/rdata    load data return, sampled only while waiting
//   wb_result           register-file write data
//   wb_reg_to_write     register-file write index
//   wb_reg_write        one-cycle write strobe (never for $0)
//   wb_stall            high while a load is outstanding
//   wb_halt             sticky halt flag
//   retire_count        retired-instruction count
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned REG_AW = 5,
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned AW     = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [31:0]       in_pc_plus4,
    input  logic [AW-1:0]     in_addr_lo,
    input  logic [REG_AW-1:0] in_reg_to_write,
    input  logic              in_c_reg_write,
    input  logic              in_c_data_source,
    input  logic              in_c_sign,
    input  logic              in_c_halt,
    input  logic [1:0]        in_c_jump,
    input  logic [1:0]        in_c_size,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_AW-1:0] wb_reg_to_write,
    output logic              wb_reg_write,
    output logic              wb_stall,
    output logic              wb_halt,
    output logic [CNT_W-1:0]  retire_count
);

    wb_state_t         state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              we_q, we_d;
    wb_ld_ctrl_t       ld_ctrl_q, ld_ctrl_d;
    logic [AW-1:0]     ld_addr_q, ld_addr_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [DATA_W-1:0] align_data;
    logic              is_load_c;

    // A jump always links, even if data_source is set.
    assign is_load_c = (in_c_jump == 2'b00) && in_c_data_source;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata   (mem_rdata),
        .addr_lo (ld_addr_q),
        .size    (ld_ctrl_q.size),
        .sign    (ld_ctrl_q.sign),
        .ext     (align_data)
    );

    // Sequencer next-state and write-back slot computation.
    // Result/index only update when a strobe will fire, so they hold otherwise.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        rd_d      = rd_q;
        we_d      = 1'b0;
        ld_ctrl_d = ld_ctrl_q;
        ld_addr_d = ld_addr_q;
        ld_rd_d   = ld_rd_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_load_c) begin
                        ld_ctrl_d = '{reg_write: in_c_reg_write,
                                      sign:      in_c_sign,
                                      halt:      in_c_halt,
                                      size:      in_c_size};
                        ld_addr_d = in_addr_lo;
                        ld_rd_d   = in_reg_to_write;
                        state_d   = WAIT_LOAD;
                    end else begin
                        we_d = in_c_reg_write && (in_reg_to_write != '0);
                        if (we_d) begin
                            result_d = (in_c_jump != 2'b00) ? DATA_W'(in_pc_plus4)
                                                            : in_alu_out;
                            rd_d     = in_reg_to_write;
                        end
                        if (in_c_halt) begin
                            state_d = HALTED;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    we_d = ld_ctrl_q.reg_write && (ld_rd_q != '0);
                    if (we_d) begin
                        result_d = align_data;
                        rd_d     = ld_rd_q;
                    end
                    state_d = ld_ctrl_q.halt ? HALTED : IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and write-back registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            ld_ctrl_q <= '0;
            ld_addr_q <= '0;
            ld_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            ld_ctrl_q <= ld_ctrl_d;
            ld_addr_q <= ld_addr_d;
            ld_rd_q   <= ld_rd_d;
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign wb_stall        = (state_q == WAIT_LOAD);
    assign wb_halt         = (state_q == HALTED);
    assign wb_result       = result_q;
    assign wb_reg_to_write = rd_q;
    assign wb_reg_write    = we_q;

`ifdef WB_RETIRE_CNT_EN
    logic             retire_c;
    logic [CNT_W-1:0] cnt_q;

    // A slot completes on every non-load transfer and every load data return.
    assign retire_c = ((state_q == IDLE) && in_valid && !is_load_c) ||
                      ((state_q == WAIT_LOAD) && mem_rvalid);

    // Saturating count, updated on the same edge that registers the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retire_count = cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_alu_out;
    logic [31:0]       in_pc_plus4;
    logic [1:0]        in_addr_lo;
    logic [4:0]        in_reg_to_write;
    logic              in_c_reg_write;
    logic              in_c_data_source;
    logic              in_c_sign;
    logic              in_c_halt;
    logic [1:0]        in_c_jump;
    logic [1:0]        in_c_size;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic [31:0]       wb_result;
    logic [4:0]        wb_reg_to_write;
    logic              wb_reg_write;
    logic              wb_stall;
    logic              wb_halt;
    logic [31:0]       retire_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt;

    wb_stage_pipe #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_out       (in_alu_out),
        .in_pc_plus4      (in_pc_plus4),
        .in_addr_lo       (in_addr_lo),
        .in_reg_to_write  (in_reg_to_write),
        .in_c_reg_write   (in_c_reg_write),
        .in_c_data_source (in_c_data_source),
        .in_c_sign        (in_c_sign),
        .in_c_halt        (in_c_halt),
        .in_c_jump        (in_c_jump),
        .in_c_size        (in_c_size),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .wb_result        (wb_result),
        .wb_reg_to_write  (wb_reg_to_write),
        .wb_reg_write     (wb_reg_write),
        .wb_stall         (wb_stall),
        .wb_halt          (wb_halt),
        .retire_count     (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load result: pick nbytes at the naturally aligned offset,
    // then zero- or sign-extend to 32 bits.
    function automatic logic [31:0] model_load(logic [31:0] rdata, int addr, int size, bit sgn);
        int          nb;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        nb   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        off  = addr - (addr % nb);
        v    = 64'(rdata) >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sgn && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_count();
        return CNT_EN ? exp_cnt : 32'd0;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_alu_out = 0; in_pc_plus4 = 0; in_addr_lo = 0;
        in_reg_to_write = 0; in_c_reg_write = 0; in_c_data_source = 0;
        in_c_sign = 0; in_c_halt = 0; in_c_jump = 0; in_c_size = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wb_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", wb_reg_to_write); end
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_reg_write); end
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", wb_stall); end
        checks++; if (wb_halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", wb_halt); end
        checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", retire_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_nonload_back_to_back();
        in_valid = 1; in_alu_out = 32'h1234; in_reg_to_write = 7; in_c_reg_write = 1;
        @(negedge clk);
        exp_cnt++;
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL nl_a_we got=%b exp=1", wb_reg_write); end
        checks++; if (wb_result !== 32'h1234) begin failures++; $display("FAIL nl_a_result got=%h exp=00001234", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd7) begin failures++; $display("FAIL nl_a_rd got=%0d exp=7", wb_reg_to_write); end
        in_alu_out = 32'hABCD0055; in_reg_to_write = 9;
        @(negedge clk);
        exp_cnt++;
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL nl_b_we got=%b exp=1", wb_reg_write); end
        checks++; if (wb_result !== 32'hABCD0055) begin failures++; $display("FAIL nl_b_result got=%h exp=abcd0055", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd9) begin failures++; $display("FAIL nl_b_rd got=%0d exp=9", wb_reg_to_write); end
        idle_inputs();
        @(negedge clk);
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL nl_idle_we got=%b exp=0", wb_reg_write); end
        checks++; if (wb_result !== 32'hABCD0055) begin failures++; $display("FAIL nl_hold_result got=%h exp=abcd0055", wb_result); end
    endtask

    task automatic test_load_byte_signed();
        in_valid = 1; in_c_data_source = 1; in_c_size = 2'b00; in_addr_lo = 2;
        in_c_sign = 1; in_reg_to_write = 5; in_c_reg_write = 1; in_alu_out = 32'hDEAD;
        mem_rvalid = 1; mem_rdata = 32'h11111111;   // ignored while idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 0; mem_rvalid = 0;
            checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL ld_stall cyc=%0d got=%b exp=1", i, wb_stall); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ld_ready cyc=%0d got=%b exp=0", i, in_ready); end
            checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL ld_early_we cyc=%0d got=%b exp=0", i, wb_reg_write); end
        end
        mem_rvalid = 1; mem_rdata = 32'h0080FF00;
        @(negedge clk);
        exp_cnt++;
        mem_rvalid = 0;
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL ld_we got=%b exp=1", wb_reg_write); end
        checks++; if (wb_result !== 32'hFFFFFF80) begin failures++; $display("FAIL ld_result got=%h exp=ffffff80", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd5) begin failures++; $display("FAIL ld_rd got=%0d exp=5", wb_reg_to_write); end
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL ld_stall_end got=%b exp=0", wb_stall); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ld_ready_end got=%b exp=1", in_ready); end
        idle_inputs();
    endtask

    task automatic test_jump_link();
        in_valid = 1; in_c_jump = 2'b10; in_pc_plus4 = 32'h400; in_c_data_source = 1;
        in_reg_to_write = 31; in_c_reg_write = 1; in_alu_out = 32'h999;
        @(negedge clk);
        exp_cnt++;
        idle_inputs();
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL jal_we got=%b exp=1", wb_reg_write); end
        checks++; if (wb_result !== 32'h400) begin failures++; $display("FAIL jal_result got=%h exp=00000400", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd31) begin failures++; $display("FAIL jal_rd got=%0d exp=31", wb_reg_to_write); end
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL jal_stall got=%b exp=0", wb_stall); end
    endtask

    task automatic test_write_zero();
        in_valid = 1; in_c_reg_write = 1; in_reg_to_write = 0; in_alu_out = 32'h5555;
        @(negedge clk);
        exp_cnt++;
        idle_inputs();
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL r0_we got=%b exp=0", wb_reg_write); end
        checks++; if (wb_result !== 32'h400) begin failures++; $display("FAIL r0_hold_result got=%h exp=00000400", wb_result); end
        checks++; if (wb_reg_to_write !== 5'd31) begin failures++; $display("FAIL r0_hold_rd got=%0d exp=31", wb_reg_to_write); end
        @(negedge clk);
        checks++; if (retire_count !== exp_count()) begin failures++; $display("FAIL r0_count got=%0d exp=%0d", retire_count, exp_count()); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        in_valid = 1; in_c_data_source = 1; in_c_size = 2'b10; in_reg_to_write = 6; in_c_reg_write = 1;
        @(negedge clk);
        idle_inputs();
        checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL rml_stall got=%b exp=1", wb_stall); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL rml_stall_after got=%b exp=0", wb_stall); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rml_ready got=%b exp=1", in_ready); end
        checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL rml_count got=%0d exp=0", retire_count); end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL rml_we cyc=%0d got=%b exp=0", i, wb_reg_write); end
            checks++; if (wb_result !== 32'd0) begin failures++; $display("FAIL rml_result cyc=%0d got=%h exp=0", i, wb_result); end
        end
        idle_inputs();
    endtask

    task automatic test_halt_load();
        do_reset();
        in_valid = 1; in_c_data_source = 1; in_c_size = 2'b10; in_addr_lo = 1;
        in_reg_to_write = 4; in_c_reg_write = 1; in_c_halt = 1;
        @(negedge clk);
        idle_inputs();
        checks++; if (wb_halt !== 1'b0) begin failures++; $display("FAIL hl_halt_early got=%b exp=0", wb_halt); end
        mem_rvalid = 1; mem_rdata = 32'hCAFEBABE;
        @(negedge clk);
        exp_cnt++;
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL hl_we got=%b exp=1", wb_reg_write); end
        checks++; if (wb_result !== 32'hCAFEBABE) begin failures++; $display("FAIL hl_result got=%h exp=cafebabe", wb_result); end
        checks++; if (wb_halt !== 1'b1) begin failures++; $display("FAIL hl_halt got=%b exp=1", wb_halt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hl_ready got=%b exp=0", in_ready); end
        in_valid = 1; in_c_data_source = 0; in_alu_out = 32'h77; in_reg_to_write = 3;
        in_c_reg_write = 1; in_addr_lo = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL hl_post_we cyc=%0d got=%b exp=0", i, wb_reg_write); end
            checks++; if (wb_halt !== 1'b1) begin failures++; $display("FAIL hl_sticky cyc=%0d got=%b exp=1", i, wb_halt); end
            checks++; if (wb_result !== 32'hCAFEBABE) begin failures++; $display("FAIL hl_post_result cyc=%0d got=%h exp=cafebabe", i, wb_result); end
        end
        checks++; if (retire_count !== exp_count()) begin failures++; $display("FAIL hl_count got=%0d exp=%0d", retire_count, exp_count()); end
        do_reset();
        checks++; if (wb_halt !== 1'b0) begin failures++; $display("FAIL hl_reset_halt got=%b exp=0", wb_halt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hl_reset_ready got=%b exp=1", in_ready); end
    endtask

    // Random instruction stream against a transaction-level model: one
    // outstanding load at most, every slot retires, $0 writes are dropped.
    task automatic test_random();
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_we;
        bit          pend;
        logic [4:0]  p_rd;
        bit          p_rw, p_sign;
        int          p_size, p_addr;
        do_reset();
        e_res = 0; e_rd = 0; e_we = 0; pend = 0;
        p_rd = 0; p_rw = 0; p_sign = 0; p_size = 0; p_addr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (wb_reg_write !== e_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, wb_reg_write, e_we); end
            checks++; if (wb_result !== e_res) begin failures++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, wb_result, e_res); end
            checks++; if (wb_reg_to_write !== e_rd) begin failures++; $display("FAIL rnd_rd cyc=%0d got=%0d exp=%0d", cyc, wb_reg_to_write, e_rd); end
            checks++; if (wb_stall !== logic'(pend)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, wb_stall, pend); end
            checks++; if (in_ready !== logic'(!pend)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !pend); end
            checks++; if (retire_count !== exp_count()) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, retire_count, exp_count()); end

            in_valid         = ($urandom_range(0, 9) < 7);
            in_alu_out       = $urandom;
            in_pc_plus4      = $urandom;
            in_addr_lo       = 2'($urandom_range(0, 3));
            in_reg_to_write  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_c_reg_write   = ($urandom_range(0, 4) != 0);
            in_c_data_source = 1'($urandom_range(0, 1));
            in_c_sign        = 1'($urandom_range(0, 1));
            in_c_halt        = 1'b0;
            in_c_jump        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            in_c_size        = 2'($urandom_range(0, 3));
            mem_rvalid       = 1'($urandom_range(0, 1));
            mem_rdata        = $urandom;

            e_we = 1'b0;
            if (!pend) begin
                if (in_valid) begin
                    if (in_c_jump == 2'b00 && in_c_data_source) begin
                        pend = 1; p_rd = in_reg_to_write; p_rw = in_c_reg_write;
                        p_sign = in_c_sign; p_size = int'(in_c_size); p_addr = int'(in_addr_lo);
                    end else begin
                        e_we = in_c_reg_write && (in_reg_to_write != 0);
                        if (e_we) begin
                            e_res = (in_c_jump != 0) ? in_pc_plus4 : in_alu_out;
                            e_rd  = in_reg_to_write;
                        end
                        exp_cnt++;
                    end
                end
            end else if (mem_rvalid) begin
                e_we = p_rw && (p_rd != 0);
                if (e_we) begin
                    e_res = model_load(mem_rdata, p_addr, p_size, p_sign);
                    e_rd  = p_rd;
                end
                pend = 0;
                exp_cnt++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        exp_cnt = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_nonload_back_to_back();
        test_load_byte_signed();
        test_jump_link();
        test_write_zero();
        test_reset_mid_load();
        test_halt_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, registered write-back stage for the MIPS pipeline. It replaces the purely combinational write-back path. It accepts one retiring instruction per cycle from MEM over a valid/ready handshake and waits for variable-latency load data from the data memory. It aligns and extends sub-word loads using the byte offset, selects the link value for jumps, and drives a registered one-cycle register-file write strobe. It also keeps a sticky halt state.

## Interface
- DATA_W, 32: datapath width; legal values are 32 and 64.
- REG_AW, 5: register-index width.
- CNT_W, 32: retire-counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage accepts; transfer occurs when in_valid && in_ready.
- in_alu_out  in  DATA_W  ALU result.
- in_pc_plus4  in  32  link value; zero-extended to DATA_W.
- in_addr_lo  in  log2(DATA_W/8)  load byte offset.
- in_reg_to_write  in  REG_AW  destination register.
- in_c_reg_write, in_c_data_source, in_c_sign, in_c_halt  in  1 each  control bits; data_source=1 means load.
- in_c_jump  in  2  any nonzero value selects the link value.
- in_c_size  in  2  load size: 00 byte, 01 half, 10 word, 11 dword.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  raw load data.
- wb_result  out  DATA_W  register-file write data.
- wb_reg_to_write  out  REG_AW  register-file write index.
- wb_reg_write  out  1  one-cycle write strobe.
- wb_stall  out  1  high while waiting for load data.
- wb_halt  out  1  sticky halt flag.
- retire_count  out  CNT_W  count of retired instructions.

## Operation
- Three states: IDLE, WAIT_LOAD, HALTED. Reset enters IDLE.
- in_ready = (state==IDLE).
- Transfer in IDLE when the instruction is not a load (in_c_jump!=0 or in_c_data_source=0):
  - Result is the link value if in_c_jump!=0, otherwise in_alu_out.
  - Result is registered; the write strobe fires the next cycle.
- Transfer in IDLE when the instruction is a load (in_c_jump==0 and in_c_data_source=1):
  - Latch the control bits, in_addr_lo and in_reg_to_write, then go to WAIT_LOAD.
- WAIT_LOAD:
  - mem_rvalid is sampled only in this state.
  - When mem_rvalid is seen, register the aligned and extended data, fire the strobe next cycle, and return to IDLE.
  - mem_rvalid in IDLE or HALTED is ignored.
- Load alignment:
  - Byte: rdata >> (8*addr_lo).
  - Half: uses addr_lo with bit 0 forced to 0.
  - Word: uses addr_lo with bits [1:0] forced to 0.
  - Dword: no shift.
  - After the shift, the value is zero-extended, or sign-extended when in_c_sign=1, to DATA_W.
  - With DATA_W=32, size 11 is treated as word.
- Write strobe: wb_reg_write = latched reg_write && latched reg_to_write!=0. Writes to $0 are suppressed, but the instruction still retires.
- Halt:
  - An accepted instruction with in_c_halt=1 completes its own write-back normally (including a load wait).
  - The stage then enters HALTED, where wb_halt=1 and in_ready=0 until rst.
- wb_stall = (state==WAIT_LOAD).
- Reset at any time, including mid-WAIT_LOAD:
  - Any pending load is dropped.
  - All outputs reach their reset values on the next edge.
- Reset values: wb_result=0, wb_reg_to_write=0, wb_reg_write=0, wb_halt=0, wb_stall=0, retire_count=0, state=IDLE.

## Timing
- Non-load: transfer at edge N gives the strobe, result and index valid during cycle N+1.
- Load: transfer at N; mem_rvalid sampled at edge M>N gives the strobe during M+1. Minimum load latency is 2 cycles. in_ready returns high in cycle M+1.
- Back-to-back non-load transfers sustain one write per cycle.
- wb_result and wb_reg_to_write hold their last value while no strobe is issued.
- Halt: wb_halt asserts in the same cycle as the halting instruction's strobe slot.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_count increments by 1 on every retire (every cycle in which a write-back slot completes), whether or not it writes.
  - It saturates at 2^CNT_W−1.
- WB_RETIRE_CNT_EN undefined:
  - The port remains, tied to 0.
  - No counter logic is generated.

## Structure
- Package wb_pkg holds:
  - The load-size localparams SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - The state enum wb_state_t {IDLE, WAIT_LOAD, HALTED}.
- Sub-module wb_load_align is purely combinational.
  - Inputs: rdata, addr_lo, size, sign.
  - Output: the extended data.
  - It is verified standalone.

## Test plan
- Non-load: DATA_W=32, in_alu_out=0x1234, reg 7, reg_write=1 → strobe in N+1 with result 0x1234 and index 7. A back-to-back second op strobes in N+2.
- Load byte, signed: addr_lo=2, mem_rdata=0x0080FF00 after a 3-cycle wait → wb_stall=1 for 3 cycles, then result 0xFFFFFF80. in_ready=0 throughout the wait.
- Jump-and-link: in_c_jump=10, pc_plus4=0x400, data_source=1 → no wait, result 0x400.
- Write to $0: reg_write=1 with reg_to_write=0 → no strobe, but retire_count increments with WB_RETIRE_CNT_EN.
- Halt with load: halt=1 load, then rvalid → strobe, then wb_halt=1 and in_ready=0. New in_valid is ignored until rst.
- rst during WAIT_LOAD → IDLE next cycle. A later mem_rvalid produces no strobe.
